mmio_waitstate_ctrl: RTL and testbench

Parametrised MMIO slot controller: decodes the CPU-side MMIO bus into per-slot strobes for up to 64 slots and adds a ready/wait-state handshake. Slots may stretch an access; slots that never respond are timed out, and unmapped slots are answered locally. Sits between the bus bridge and the slot cores inside the MMIO subsystem. Replaces the fixed-latency controller for designs with slow peripherals.

---
 rtl/mmio_waitstate_ctrl_if.sv | 20 ++
 rtl/mmio_waitstate_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmio_waitstate_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_waitstate_ctrl_if.sv
// CPU-side MMIO bus between the bus bridge (master) and the slot controller (slave).
interface mmio_waitstate_ctrl_if;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        mmio_ready;

  modport master (
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data, mmio_ready
  );

  modport slave (
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data, mmio_ready
  );
endinterface

// File: rtl/mmio_waitstate_ctrl.sv
// MMIO slot controller: decodes CPU MMIO accesses into one-hot slot strobes,
// waits for the addressed slot to answer, times out silent slots and answers
// unmapped slots locally. All outputs are registered.
module mmio_waitstate_ctrl #(
  parameter int          N_SLOT        = 64,
  parameter int          SLOT_BITS     = 6,
  parameter int          REG_BITS      = 5,
  parameter logic [63:0] SLOT_MASK     = 64'h0000_0000_0000_000D,
  parameter int          TIMEOUT       = 16,
  parameter logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_waitstate_ctrl_if.slave   mmio,
  input  logic                   err_clr,
  output logic                   err_timeout,
  output logic                   err_unmapped,
  output logic [N_SLOT-1:0]      slot_cs,
  output logic [N_SLOT-1:0]      slot_rd,
  output logic [N_SLOT-1:0]      slot_wr,
  output logic [REG_BITS-1:0]    slot_reg_addr,
  output logic [31:0]            slot_wr_data,
  input  logic [32*N_SLOT-1:0]   slot_rd_data,
  input  logic [N_SLOT-1:0]      slot_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Populated slots that also exist: anything at or above N_SLOT is unmapped.
  localparam logic [63:0]       MAP_MASK = SLOT_MASK & ~({64{1'b1}} << N_SLOT);

  state_t               state_q, state_n;
  logic [SLOT_BITS-1:0] slot_q, slot_n;
  logic                 is_wr_q, is_wr_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 ready_q, ready_n;
  logic [31:0]          rd_data_q, rd_data_n;
  logic [N_SLOT-1:0]    cs_n, rd_n, wr_n;
  logic [REG_BITS-1:0]  reg_addr_n;
  logic [31:0]          wr_data_n;
  logic                 set_timeout, set_unmapped;

  logic [SLOT_BITS-1:0] req_slot;
  logic [REG_BITS-1:0]  req_reg;
  logic                 req_valid;
  logic [N_SLOT-1:0]    req_onehot;
  logic                 sel_ready;
  logic [31:0]          sel_data;
  logic [31:0]          ok_data;
  logic                 unused_addr_bits;

  assign req_slot   = mmio.mmio_addr[REG_BITS+SLOT_BITS-1:REG_BITS];
  assign req_reg    = mmio.mmio_addr[REG_BITS-1:0];
  assign req_valid  = mmio.mmio_cs & (mmio.mmio_rd | mmio.mmio_wr);
  assign req_onehot = N_SLOT'(64'd1 << req_slot);
  assign sel_ready  = slot_ready[slot_q];
  assign sel_data   = slot_rd_data[{slot_q, 5'b0} +: 32];
  assign ok_data    = is_wr_q ? 32'h0 : sel_data;

  // Upper address bits are not decoded.
  assign unused_addr_bits = ^mmio.mmio_addr[20:REG_BITS+SLOT_BITS];

  assign mmio.mmio_ready   = ready_q;
  assign mmio.mmio_rd_data = rd_data_q;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n      = state_q;
    slot_n       = slot_q;
    is_wr_n      = is_wr_q;
    cnt_n        = cnt_q;
    reg_addr_n   = slot_reg_addr;
    wr_data_n    = slot_wr_data;
    cs_n         = '0;
    rd_n         = '0;
    wr_n         = '0;
    ready_n      = 1'b0;
    rd_data_n    = '0;
    set_timeout  = 1'b0;
    set_unmapped = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          slot_n     = req_slot;
          reg_addr_n = req_reg;
          wr_data_n  = mmio.mmio_wr_data;
          is_wr_n    = mmio.mmio_wr;        // rd & wr together is a write
          if (MAP_MASK[req_slot]) begin
            state_n = ACCESS;
            cs_n    = req_onehot;
            if (mmio.mmio_wr) wr_n = req_onehot;
            else              rd_n = req_onehot;
          end else begin
            state_n      = DONE;
            ready_n      = 1'b1;
            rd_data_n    = UNMAPPED_DATA;
            set_unmapped = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_n = CNT_W'(1);                  // the strobe cycle counts as the first
        if (sel_ready) begin
          state_n   = DONE;
          ready_n   = 1'b1;
          rd_data_n = ok_data;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          state_n   = DONE;
          ready_n   = 1'b1;
          rd_data_n = ok_data;
        end else if (cnt_q >= CNT_LAST) begin
          state_n     = DONE;
          ready_n     = 1'b1;
          rd_data_n   = UNMAPPED_DATA;
          set_timeout = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched request and registered outputs; sticky flags give set priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      is_wr_q       <= 1'b0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      rd_data_q     <= '0;
      slot_cs       <= '0;
      slot_rd       <= '0;
      slot_wr       <= '0;
      slot_reg_addr <= '0;
      slot_wr_data  <= '0;
      err_timeout   <= 1'b0;
      err_unmapped  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_n;
      slot_q        <= slot_n;
      is_wr_q       <= is_wr_n;
      cnt_q         <= cnt_n;
      ready_q       <= ready_n;
      rd_data_q     <= rd_data_n;
      slot_cs       <= cs_n;
      slot_rd       <= rd_n;
      slot_wr       <= wr_n;
      slot_reg_addr <= reg_addr_n;
      slot_wr_data  <= wr_data_n;
      err_timeout   <= set_timeout  | (err_timeout  & ~err_clr);
      err_unmapped  <= set_unmapped | (err_unmapped & ~err_clr);
    end
  end

endmodule

// File: tb/tb_mmio_waitstate_ctrl.sv
// Self-checking bench for mmio_waitstate_ctrl: directed steps followed by
// randomized accesses, all checked against a latency/data/flag model.
module tb_mmio_waitstate_ctrl;

  localparam int          N_SLOT    = 64;
  localparam int          TIMEOUT   = 16;
  localparam logic [63:0] SLOT_MASK = 64'h0000_0000_0000_000D;
  localparam logic [31:0] UNM       = 32'hFFFF_FFFF;

  logic                  clk;
  logic                  reset;
  logic                  err_clr;
  logic                  err_timeout, err_unmapped;
  logic [N_SLOT-1:0]     slot_cs, slot_rd, slot_wr;
  logic [4:0]            slot_reg_addr;
  logic [31:0]           slot_wr_data;
  logic [32*N_SLOT-1:0]  slot_rd_data;
  logic [N_SLOT-1:0]     slot_ready;

  mmio_waitstate_ctrl_if bus ();

  mmio_waitstate_ctrl #(
    .N_SLOT(N_SLOT), .SLOT_BITS(6), .REG_BITS(5), .SLOT_MASK(SLOT_MASK),
    .TIMEOUT(TIMEOUT), .UNMAPPED_DATA(UNM)
  ) dut (
    .clk(clk), .reset(reset), .mmio(bus), .err_clr(err_clr),
    .err_timeout(err_timeout), .err_unmapped(err_unmapped),
    .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data(slot_rd_data), .slot_ready(slot_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_um = 0;
  bit exp_to = 0;

  // Slot responder: target slot answers rdy_delay cycles after its strobe
  // (-1 = never); every other ready bit is random noise.
  int rdy_slot  = 0;
  int rdy_delay = -1;
  bit active    = 0;
  int since     = 0;
  logic [63:0] noise;

  always @(negedge clk) begin
    noise = {$urandom, $urandom};
    if (reset || bus.mmio_ready) active = 0;
    else if (slot_cs[rdy_slot]) begin
      active = 1;
      since  = 0;
    end else if (active) since++;
    if (active) noise[rdy_slot] = (rdy_delay >= 0) && (since >= rdy_delay);
    slot_ready = noise;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access, starting and ending at a negedge. Expectations come from the
  // timing rules: unmapped -> 1 cycle, ready k cycles after strobe -> 2+k,
  // silent for TIMEOUT cycles -> 1+TIMEOUT.
  task automatic do_access(input int s, input logic [4:0] r, input bit wr, input bit both,
                           input logic [31:0] wd, input int dly, input bit busy_req,
                           input bit pin, input logic [31:0] pin_val);
    bit          mapped, ok, seen;
    int          lat_exp, cyc, n_strobe;
    logic [31:0] d_exp;
    logic [63:0] oh;
    for (int i = 0; i < N_SLOT; i++) slot_rd_data[32*i +: 32] = $urandom;
    if (pin) slot_rd_data[32*s +: 32] = pin_val;
    mapped  = (s < N_SLOT) && (SLOT_MASK[s] == 1'b1);
    ok      = mapped && (dly >= 0) && (dly <= TIMEOUT - 1);
    lat_exp = !mapped ? 1 : (ok ? 2 + dly : 1 + TIMEOUT);
    d_exp   = !ok ? UNM : (wr ? 32'h0 : slot_rd_data[32*s +: 32]);
    oh      = 64'd1 << s;
    if (!mapped) exp_um = 1;
    if (mapped && !ok) exp_to = 1;
    rdy_slot  = s;
    rdy_delay = dly;

    bus.mmio_addr    = {10'($urandom), 6'(s), r};
    bus.mmio_cs      = 1'b1;
    bus.mmio_wr      = wr;
    bus.mmio_rd      = !wr || both;
    bus.mmio_wr_data = wd;
    @(posedge clk); #1;
    bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0; bus.mmio_wr = 1'b0;
    bus.mmio_addr = 21'($urandom);

    cyc = 0; seen = 0; n_strobe = 0;
    while (!seen && cyc < TIMEOUT + 6) begin
      @(negedge clk);
      cyc++;
      if (busy_req) begin
        bus.mmio_cs   = (cyc <= 2);
        bus.mmio_rd   = (cyc <= 2);
        bus.mmio_addr = {10'd0, 6'd0, 5'd1};
      end
      if ((|slot_cs) || (|slot_rd) || (|slot_wr)) begin
        n_strobe++;
        check("strobe_cycle", cyc, 1);
        check("slot_cs", slot_cs, oh);
        check("slot_rd", slot_rd, wr ? 64'd0 : oh);
        check("slot_wr", slot_wr, wr ? oh : 64'd0);
        check("slot_reg_addr", slot_reg_addr, r);
        check("slot_wr_data", slot_wr_data, wd);
      end
      if (bus.mmio_ready) seen = 1;
    end
    bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0;
    check("done_seen", seen, 1);
    check("latency", cyc, lat_exp);
    check("rd_data", bus.mmio_rd_data, d_exp);
    check("strobe_count", n_strobe, mapped ? 1 : 0);
    check("err_unmapped", err_unmapped, exp_um);
    check("err_timeout", err_timeout, exp_to);
    @(negedge clk);
    check("ready_single", bus.mmio_ready, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_um = 0; exp_to = 0;
    check("clr_unmapped", err_unmapped, 0);
    check("clr_timeout", err_timeout, 0);
  endtask

  initial begin
    int s, dly, pick;
    reset = 1'b1; err_clr = 1'b0;
    bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0; bus.mmio_wr = 1'b0;
    bus.mmio_addr = '0; bus.mmio_wr_data = '0;
    slot_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.mmio_ready, 0);
    check("rst_rd_data", bus.mmio_rd_data, 0);
    check("rst_cs", slot_cs, 0);
    check("rst_rd", slot_rd, 0);
    check("rst_wr", slot_wr, 0);
    check("rst_reg_addr", slot_reg_addr, 0);
    check("rst_wr_data", slot_wr_data, 0);
    check("rst_err_to", err_timeout, 0);
    check("rst_err_um", err_unmapped, 0);
    reset = 1'b0;
    @(negedge clk);

    // Read slot 0 reg 3, immediate ready.
    do_access(0, 5'd3, 0, 0, 32'h0, 0, 0, 1, 32'h1234_5678);
    // Write slot 2, ready 4 cycles after strobe.
    do_access(2, 5'd9, 1, 0, 32'h0000_00A5, 4, 0, 0, 32'h0);
    // Unmapped read of slot 5, then clear.
    do_access(5, 5'd0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    pulse_clr();
    // Silent slot 3 times out, then a normal read of slot 3.
    do_access(3, 5'd4, 0, 0, 32'h0, -1, 0, 0, 32'h0);
    do_access(3, 5'd4, 0, 0, 32'h0, 2, 0, 0, 32'h0);
    // Timeout boundary: last cycle that still succeeds, first that fails.
    do_access(2, 5'd1, 0, 0, 32'h0, TIMEOUT - 1, 0, 0, 32'h0);
    do_access(2, 5'd1, 1, 0, 32'hDEAD_BEEF, TIMEOUT, 0, 0, 32'h0);

    // Reset while waiting on slot 2.
    rdy_slot = 2; rdy_delay = -1;
    bus.mmio_addr = {10'd0, 6'd2, 5'd7};
    bus.mmio_cs = 1'b1; bus.mmio_rd = 1'b1; bus.mmio_wr_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("pre_rst_ready", bus.mmio_ready, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_um = 0; exp_to = 0;
    check("mid_rst_ready", bus.mmio_ready, 0);
    check("mid_rst_rd_data", bus.mmio_rd_data, 0);
    check("mid_rst_cs", slot_cs, 0);
    check("mid_rst_rd", slot_rd, 0);
    check("mid_rst_reg_addr", slot_reg_addr, 0);
    check("mid_rst_wr_data", slot_wr_data, 0);
    check("mid_rst_err_to", err_timeout, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_ready", bus.mmio_ready, 0);
    end
    do_access(2, 5'd7, 0, 0, 32'h0, 1, 0, 0, 32'h0);

    // rd and wr together is a write; a request while busy is ignored.
    do_access(2, 5'd2, 1, 1, 32'h0BAD_F00D, 3, 1, 0, 32'h0);

    // Set and clear in the same cycle: set wins.
    rdy_slot = 5; rdy_delay = -1;
    bus.mmio_addr = {10'd0, 6'd5, 5'd0};
    bus.mmio_cs = 1'b1; bus.mmio_rd = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    bus.mmio_cs = 1'b0; bus.mmio_rd = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    exp_um = 1;
    check("set_wins_ready", bus.mmio_ready, 1);
    check("set_wins_um", err_unmapped, exp_um);
    @(negedge clk);

    // Randomized accesses, issued back to back.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      s = (pick == 0) ? 0 : (pick == 1) ? 2 : (pick == 2) ? 3 : $urandom_range(0, 63);
      pick = $urandom_range(0, 9);
      dly = (pick == 0) ? -1 : (pick == 1) ? $urandom_range(TIMEOUT - 1, TIMEOUT)
                                           : $urandom_range(0, 5);
      do_access(s, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, dly, 0, 0, 32'h0);
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
